tile_accum_buffer: RTL
======================

# tile_accum_buffer

Parametrised dual-port tile store for the rasteriser back end, successor to the fixed 32x32x4x16 tile buffer. Holds one tile of multi-channel pixels in block RAM. Adds a per-pixel add-with-saturate accumulate mode with a read-modify-write pipeline and hazard forwarding. Adds a single-cycle fast clear via per-pixel valid bits, so the tile can be reused without a 1024-cycle wipe.

## Interface
- TILE_W, default 32: tile width in pixels.
- TILE_H, default 32: tile height in pixels.
- CH, default 4: channels per pixel; channel 0 is in the LSBs.
- CW, default 16: bits per channel, unsigned.
- ADDR_W, derived as $clog2(TILE_W*TILE_H): pixel address width.
- PW, derived as CH*CW: pixel width.
- clk  in  1  clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  ADDR_W  read pixel index, ty*TILE_W+tx.
- rd_data  out  PW  read result.
- wr_en  in  1  write/accumulate request, one per cycle, always accepted.
- wr_addr  in  ADDR_W  target pixel.
- wr_data  in  PW  data to store or add.
- wr_accum  in  1  1 = add-saturate into the stored pixel; 0 = replace.
- clear  in  1  fast clear of the whole tile.
- busy  out  1  a write is in pipeline stage 1.

## Operation
- Storage is a PW-bit x TILE_W*TILE_H RAM plus a TILE_W*TILE_H valid-bit register array.
- A pixel whose valid bit is 0 reads as all-zero, regardless of RAM contents.
- Stage 0 (request cycle N):
  - Register addr, data and mode.
  - Issue the RAM read of wr_addr.
- Stage 1 (cycle N+1): form the old value.
  - If stage 1 of cycle N held a write to the same address, the old value is that write's result (forwarded).
  - Otherwise the old value is the RAM data, masked to 0 if the pixel is invalid.
- Stage 1 result:
  - Replace mode: wr_data.
  - Accum mode: per channel, old + new, computed in CW+1 bits and clamped to 2^CW-1.
- Commit: the result is written to RAM and the valid bit set at the edge ending N+1.
- Clear asserted in cycle N:
  - All valid bits are zeroed at that edge.
  - The stage-1 write committing at that edge is discarded.
  - A wr_en in cycle N is discarded (it never enters stage 1).
- Out-of-range address (index >= TILE_W*TILE_H):
  - Writes are dropped.
  - Reads return 0.
- Reset:
  - rd_data = 0, busy = 0, pipeline empty.
  - All valid bits = 0; RAM contents are don't-care.

## Timing
- Read latency is 1: rd_addr in cycle N gives rd_data registered at the edge ending N, visible in N+1.
- Reads observe writes committed at or before the edge ending N-1, i.e. writes requested in cycle N-2 or earlier.
- A read in the commit cycle of the same address returns the pre-write value (read-before-write).
- Write throughput is 1 per cycle, with no stalls.
- Back-to-back accumulates to the same address are exact, via forwarding.
- A request in N, followed by a request in N+2 to the same address, reads the committed RAM value; no forwarding is needed.
- busy = 1 in cycle N+1 for every accepted request made in cycle N, else 0.
- rd_data after clear: any read issued in the cycle after clear returns 0, unless that pixel was written after the clear.

## Configuration
- Macro: TILE_ACCUM_BUFFER_ACCUM_EN.
- Defined:
  - Accumulate mode, the saturating adders and the forwarding mux are built.
  - wr_accum selects the mode.
- Undefined:
  - wr_accum is ignored and every write is a replace.
  - The adders and the forwarding path are removed.
  - Pipeline latency and clear behaviour are unchanged.

## Test plan
- After reset, read every address with default parameters -> rd_data = 0 for all 1024 pixels, busy = 0.
- Replace-write 0x0004_0003_0002_0001 to addr 5 in cycle N, then read addr 5 issued at N+1 and N+2 -> old value 0 at N+1; 0x0004_0003_0002_0001 visible at N+3.
- Accumulate 0x0001_0001_0001_0001 to addr 7 on three consecutive cycles, starting from invalid -> later read = 0x0003_0003_0003_0003, exercising forwarding.
- Replace addr 9 with 0xFFF0_0010_0000_8000, then accumulate 0x0020_FFFF_0001_8000 -> read = 0xFFFF_FFFF_0001_FFFF, with saturation per channel.
- Fill 16 pixels, pulse clear in the same cycle as a write to addr 3 and a commit in flight to addr 2 -> all pixels read 0, including addrs 2 and 3.
- Build without TILE_ACCUM_BUFFER_ACCUM_EN: write 0x10 to addr 1, then accumulate 0x01 to addr 1 -> read = 0x01.

Source files
------------

// File: rtl/tile_accum_buffer.sv
// tile_accum_buffer: one-tile multi-channel pixel store with replace or saturating-accumulate writes and a one-cycle fast clear.
// Define TILE_ACCUM_BUFFER_ACCUM_EN to build the accumulate adders and the stage-1 forwarding path.
module tile_accum_buffer #(
  parameter int TILE_W = 32,
  parameter int TILE_H = 32,
  parameter int CH     = 4,
  parameter int CW     = 16,
  parameter int ADDR_W = $clog2(TILE_W*TILE_H),
  parameter int PW     = CH*CW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PW-1:0]     rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PW-1:0]     wr_data,
  input  logic              wr_accum,
  input  logic              clear,
  output logic              busy
);
  localparam int DEPTH = TILE_W*TILE_H;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  logic [PW-1:0]     ram [DEPTH];
  logic [DEPTH-1:0]  valid_reg;

  logic              wr_in_range;
  logic              rd_in_range;
  logic              wr_take;

  logic              s1_valid_reg;
  logic [ADDR_W-1:0] s1_addr_reg;
  logic [PW-1:0]     s1_data_reg;
  logic [PW-1:0]     s1_result;

  logic [PW-1:0]     rd_q_reg;
  logic              rd_ok_reg;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_X;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_X;
  // A clear in the request cycle kills the request before it reaches stage 1.
  assign wr_take     = wr_en && !clear && wr_in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_addr_reg  <= '0;
      s1_data_reg  <= '0;
      rd_ok_reg    <= 1'b0;
      valid_reg    <= '0;
    end else begin
      s1_valid_reg <= wr_take;
      if (wr_take) begin
        s1_addr_reg <= wr_addr;
        s1_data_reg <= wr_data;
      end
      rd_ok_reg <= rd_in_range && valid_reg[rd_addr];
      if (clear) begin
        valid_reg <= '0;
      end else if (s1_valid_reg) begin
        valid_reg[s1_addr_reg] <= 1'b1;
      end
    end
  end

  // RAM array kept free of reset so it maps onto block RAM; the read is read-before-write.
  always_ff @(posedge clk) begin
    rd_q_reg <= ram[rd_addr];
    if (s1_valid_reg && !clear) begin
      ram[s1_addr_reg] <= s1_result;
    end
  end

  assign rd_data = rd_ok_reg ? rd_q_reg : '0;
  assign busy    = s1_valid_reg;

`ifdef TILE_ACCUM_BUFFER_ACCUM_EN
  logic          s1_accum_reg;
  logic          s1_pix_ok_reg;
  logic          fwd_hit_reg;
  logic [PW-1:0] fwd_data_reg;
  logic [PW-1:0] ram_q_reg;
  logic [PW-1:0] old_pix;
  logic [PW-1:0] acc_pix;

  // The stage-1 write committing at this edge is invisible to the RAM read, so capture it for forwarding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_accum_reg  <= 1'b0;
      s1_pix_ok_reg <= 1'b0;
      fwd_hit_reg   <= 1'b0;
      fwd_data_reg  <= '0;
    end else if (wr_take) begin
      s1_accum_reg  <= wr_accum;
      s1_pix_ok_reg <= valid_reg[wr_addr];
      fwd_hit_reg   <= s1_valid_reg && (s1_addr_reg == wr_addr);
      fwd_data_reg  <= s1_result;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_take) begin
      ram_q_reg <= ram[wr_addr];
    end
  end

  assign old_pix = fwd_hit_reg ? fwd_data_reg : (s1_pix_ok_reg ? ram_q_reg : '0);

  genvar gi;
  for (gi = 0; gi < CH; gi++) begin : g_sat
    logic [CW:0] sum;
    assign sum = {1'b0, old_pix[gi*CW +: CW]} + {1'b0, s1_data_reg[gi*CW +: CW]};
    assign acc_pix[gi*CW +: CW] = sum[CW] ? {CW{1'b1}} : sum[CW-1:0];
  end

  assign s1_result = s1_accum_reg ? acc_pix : s1_data_reg;
`else
  logic unused_accum;
  assign unused_accum = wr_accum;
  assign s1_result    = s1_data_reg;
`endif

endmodule
